id_exe_cmd_issue: RTL and testbench
===================================

// Module: id_exe_cmd_issue
// PURPOSE
//  Instruction-decode issue stage: accepts 32-bit instruction words, decodes them into the 4-bit exe_cmd and control
//  fields consumed by the execute-stage ALU, and holds them in the ID/EXE pipeline register. Valid/ready handshake on
//  both sides; synchronous flush for branch mispredict. Produces exactly the command encoding the ALU executes.
// PARAMETERS
//  DATA_W      32  datapath / instruction width
//  REG_ADDR_W  5   register-file index width
//  IMM_W       16  immediate field width, sign-extended to DATA_W
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst_n        in   1           reset, asynchronous, active-low
//  in_valid     in   1           instruction word valid
//  in_ready     out  1           stage can accept instruction
//  in_instr     in   DATA_W      [31:26] op, [25:21] dest, [20:16] src1, [15:11] src2, [15:0] imm
//  flush        in   1           synchronous discard of all held entries
//  out_valid    out  1           decoded command valid toward EXE
//  out_ready    in   1           EXE accepts command
//  exe_cmd      out  4           ALU command
//  wb_en, mem_rd, mem_wr, is_imm  out 1 each  control flags
//  br_type      out  2           0 none, 1 BEZ, 2 BNE, 3 JMP
//  dest, src1, src2  out  REG_ADDR_W  register indices
//  imm_ext      out  DATA_W      sign-extended immediate
//  illegal      out  1           current out entry had an undefined opcode
//  err_sticky   out  1           set on any accepted illegal opcode; cleared only by reset
// BEHAVIOUR
//  - Reset: out_valid=0, all payload outputs 0, illegal=0, err_sticky=0; in_ready=1 after reset (low during reset).
//  - Opcode -> exe_cmd: ADD 1/ADDI 32/LD 36/ST 37 ->0000; SUB 3/SUBI 33 ->0010; AND 5 ->0100; OR 6 ->0101;
//    NOR 7 ->0110; XOR 8 ->0111; SLA 9 ->1000; SLL 10 ->1011; SRA 11 ->1001; SRL 12 ->1010; BEZ 40/BNE 41/JMP 42 ->0000.
//  - wb_en=1 for ALU ops and LD; mem_rd=1 LD; mem_wr=1 ST; is_imm=1 ADDI,SUBI,LD,ST,BEZ,BNE,JMP.
//  - Op 0 is NOP: legal, all flags 0, exe_cmd 0000. Any other undefined op: decoded as NOP with illegal=1.
//  - Transfer in when in_valid&in_ready; transfer out when out_valid&out_ready. Latency 1 cycle in->out.
//  - Payload held stable while out_valid & !out_ready; never changes until transfer out.
//  - Simultaneous out transfer and in transfer: new entry replaces old same edge, out_valid stays 1 (full throughput).
//  - flush=1: out_valid (and skid entry) cleared next edge; in_ready=1 that cycle; any input offered is consumed and
//    dropped; err_sticky not updated by dropped word. flush dominates all other events.
//  - Asserting rst_n low mid-transfer clears everything immediately; no partial entry survives.
// CONFIGURATION
//  - ID_EXE_SKID_EN defined: one-entry skid buffer; in_ready = !skid_valid (registered, no comb path from out_ready).
//    Input accepted while out stalled goes to skid; skid drains to out register on next out transfer. Latency still 1.
//  - Undefined: in_ready = !out_valid | out_ready (combinational from out_ready); no skid storage.
// STRUCTURE
//  - Package calab_isa_pkg: opcode localparams, EXE_CMD_* 4-bit constants (shared with ALU), br_type enum,
//    typedef decoded_cmd_t struct (all out payload fields + illegal).
//  - Sub-module instr_decoder: purely combinational in_instr -> decoded_cmd_t; top holds handshake, out reg, skid.
// TESTING
//  - ADD r3,r1,r2 (0x04611000), out_ready=1 -> next cycle out_valid=1, exe_cmd=0000, wb_en=1, dest=3, src1=1, src2=2.
//  - ADDI imm 0xFFF0 -> imm_ext=0xFFFFFFF0, is_imm=1; SRA -> 1001; SLL -> 1011; ST -> mem_wr=1, wb_en=0.
//  - Back-to-back 8 instrs, out_ready=1 -> 8 outputs in 8 consecutive cycles, order preserved.
//  - out_ready=0 for 5 cycles -> payload stable; without skid in_ready=0 after 1 entry, with skid after 2; no loss.
//  - Opcode 63 accepted -> illegal=1, exe_cmd=0000, wb_en=0, err_sticky=1 and stays 1 through later legal ops.
//  - flush with out held and in_valid=1 -> next cycle out_valid=0; rst_n low mid-stall -> all outputs 0 at once.

Source files
------------

// File: rtl/calab_isa_pkg.sv
// Shared ISA definitions for the decode stage and the execute-stage ALU:
// opcodes, 4-bit ALU command encodings, branch types and the decoded command record.
package calab_isa_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int IMM_W      = 16;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [3:0] EXE_CMD_ADD = 4'b0000;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0010;
    localparam logic [3:0] EXE_CMD_AND = 4'b0100;
    localparam logic [3:0] EXE_CMD_OR  = 4'b0101;
    localparam logic [3:0] EXE_CMD_NOR = 4'b0110;
    localparam logic [3:0] EXE_CMD_XOR = 4'b0111;
    localparam logic [3:0] EXE_CMD_SLA = 4'b1000;
    localparam logic [3:0] EXE_CMD_SLL = 4'b1011;
    localparam logic [3:0] EXE_CMD_SRA = 4'b1001;
    localparam logic [3:0] EXE_CMD_SRL = 4'b1010;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    typedef struct packed {
        logic [3:0]            exe_cmd;
        logic                  wb_en;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  is_imm;
        br_type_e              br_type;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic [DATA_W-1:0]     imm_ext;
        logic                  illegal;
    } decoded_cmd_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: 32-bit instruction word to the ALU command record.
module instr_decoder
    import calab_isa_pkg::*;
(
    input  logic [DATA_W-1:0] in_instr,
    output decoded_cmd_t      o_cmd
);

    logic [5:0] w_op;
    assign w_op = in_instr[31:26];

    always_comb begin
        o_cmd         = '0;
        o_cmd.br_type = BR_NONE;
        o_cmd.dest    = in_instr[25:21];
        o_cmd.src1    = in_instr[20:16];
        o_cmd.src2    = in_instr[15:11];
        o_cmd.imm_ext = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
        case (w_op)
            OP_NOP:  ;
            OP_ADD:  begin o_cmd.exe_cmd = EXE_CMD_ADD; o_cmd.wb_en = 1'b1; end
            OP_SUB:  begin o_cmd.exe_cmd = EXE_CMD_SUB; o_cmd.wb_en = 1'b1; end
            OP_AND:  begin o_cmd.exe_cmd = EXE_CMD_AND; o_cmd.wb_en = 1'b1; end
            OP_OR:   begin o_cmd.exe_cmd = EXE_CMD_OR;  o_cmd.wb_en = 1'b1; end
            OP_NOR:  begin o_cmd.exe_cmd = EXE_CMD_NOR; o_cmd.wb_en = 1'b1; end
            OP_XOR:  begin o_cmd.exe_cmd = EXE_CMD_XOR; o_cmd.wb_en = 1'b1; end
            OP_SLA:  begin o_cmd.exe_cmd = EXE_CMD_SLA; o_cmd.wb_en = 1'b1; end
            OP_SLL:  begin o_cmd.exe_cmd = EXE_CMD_SLL; o_cmd.wb_en = 1'b1; end
            OP_SRA:  begin o_cmd.exe_cmd = EXE_CMD_SRA; o_cmd.wb_en = 1'b1; end
            OP_SRL:  begin o_cmd.exe_cmd = EXE_CMD_SRL; o_cmd.wb_en = 1'b1; end
            OP_ADDI: begin o_cmd.exe_cmd = EXE_CMD_ADD; o_cmd.wb_en = 1'b1; o_cmd.is_imm = 1'b1; end
            OP_SUBI: begin o_cmd.exe_cmd = EXE_CMD_SUB; o_cmd.wb_en = 1'b1; o_cmd.is_imm = 1'b1; end
            OP_LD:   begin o_cmd.wb_en = 1'b1; o_cmd.mem_rd = 1'b1; o_cmd.is_imm = 1'b1; end
            OP_ST:   begin o_cmd.mem_wr = 1'b1; o_cmd.is_imm = 1'b1; end
            OP_BEZ:  begin o_cmd.is_imm = 1'b1; o_cmd.br_type = BR_BEZ; end
            OP_BNE:  begin o_cmd.is_imm = 1'b1; o_cmd.br_type = BR_BNE; end
            OP_JMP:  begin o_cmd.is_imm = 1'b1; o_cmd.br_type = BR_JMP; end
            // Undefined opcodes execute as a NOP but are flagged.
            default: o_cmd.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_exe_cmd_issue.sv
// ID/EXE issue stage: decode, pipeline register, valid/ready on both sides, flush.
// Optional one-entry skid buffer when ID_EXE_SKID_EN is defined.
module id_exe_cmd_issue
    import calab_isa_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            exe_cmd,
    output logic                  wb_en,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  is_imm,
    output logic [1:0]            br_type,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    output logic [DATA_W-1:0]     imm_ext,
    output logic                  illegal,
    output logic                  err_sticky
);

    // Handshake: a word moves in when in_valid & in_ready, and out when
    // out_valid & out_ready, both sampled at the rising edge of clk.
    decoded_cmd_t w_dec;
    decoded_cmd_t r_out;
    logic         r_out_valid;
    logic         r_err;
    logic         w_in_ready;
    logic         w_in_fire;
    logic         w_out_free;

    instr_decoder u_dec (
        .in_instr (in_instr),
        .o_cmd    (w_dec)
    );

    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && w_in_ready;

`ifdef ID_EXE_SKID_EN
    decoded_cmd_t r_skid;
    logic         r_skid_valid;

    // Ready depends only on registered skid occupancy, so out_ready never reaches in_ready.
    assign w_in_ready = rst_n && (flush || !r_skid_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) r_out <= w_dec;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign w_in_ready = rst_n && (flush || w_out_free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_out_free) begin
            r_out_valid <= w_in_fire;
            if (w_in_fire) r_out <= w_dec;
        end
    end
`endif

    // Words consumed during a flush are dropped and must not raise the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (!flush && w_in_fire && w_dec.illegal) begin
            r_err <= 1'b1;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign exe_cmd    = r_out.exe_cmd;
    assign wb_en      = r_out.wb_en;
    assign mem_rd     = r_out.mem_rd;
    assign mem_wr     = r_out.mem_wr;
    assign is_imm     = r_out.is_imm;
    assign br_type    = r_out.br_type;
    assign dest       = r_out.dest;
    assign src1       = r_out.src1;
    assign src2       = r_out.src2;
    assign imm_ext    = r_out.imm_ext;
    assign illegal    = r_out.illegal;
    assign err_sticky = r_err;

endmodule

// File: tb/tb_id_exe_cmd_issue.sv
// Self-checking bench for id_exe_cmd_issue: reference decoder, expected-result queue,
// directed decode cases, throughput, stall, flush, illegal opcode and mid-stall reset.
module tb_id_exe_cmd_issue;

  localparam int W = 58;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  exe_cmd;
  logic        wb_en, mem_rd, mem_wr, is_imm;
  logic [1:0]  br_type;
  logic [4:0]  dest, src1, src2;
  logic [31:0] imm_ext;
  logic        illegal;
  logic        err_sticky;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic in_fired;

  int legal_ops [18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

  id_exe_cmd_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exe_cmd    (exe_cmd),
    .wb_en      (wb_en),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .is_imm     (is_imm),
    .br_type    (br_type),
    .dest       (dest),
    .src1       (src1),
    .src2       (src2),
    .imm_ext    (imm_ext),
    .illegal    (illegal),
    .err_sticky (err_sticky)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] get_out();
    return {exe_cmd, wb_en, mem_rd, mem_wr, is_imm, br_type, dest, src1, src2, imm_ext, illegal};
  endfunction

  // Reference decode written straight from the opcode table.
  function automatic logic [W-1:0] model(input logic [31:0] ins);
    logic [3:0] cmd;
    logic wb, rd, wr, im, ill;
    logic [1:0] br;
    logic [31:0] sx;
    cmd = 4'b0000; wb = 0; rd = 0; wr = 0; im = 0; ill = 0; br = 2'd0;
    case (int'(ins[31:26]))
      0:  ;
      1:  wb = 1;
      3:  begin cmd = 4'b0010; wb = 1; end
      5:  begin cmd = 4'b0100; wb = 1; end
      6:  begin cmd = 4'b0101; wb = 1; end
      7:  begin cmd = 4'b0110; wb = 1; end
      8:  begin cmd = 4'b0111; wb = 1; end
      9:  begin cmd = 4'b1000; wb = 1; end
      10: begin cmd = 4'b1011; wb = 1; end
      11: begin cmd = 4'b1001; wb = 1; end
      12: begin cmd = 4'b1010; wb = 1; end
      32: begin wb = 1; im = 1; end
      33: begin cmd = 4'b0010; wb = 1; im = 1; end
      36: begin wb = 1; rd = 1; im = 1; end
      37: begin wr = 1; im = 1; end
      40: begin im = 1; br = 2'd1; end
      41: begin im = 1; br = 2'd2; end
      42: begin im = 1; br = 2'd3; end
      default: ill = 1;
    endcase
    sx = ins[15] ? {16'hFFFF, ins[15:0]} : {16'h0000, ins[15:0]};
    return {cmd, wb, rd, wr, im, br, ins[25:21], ins[20:16], ins[15:11], sx, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    op = 6'(legal_ops[$urandom_range(17, 0)]);
    return {op, 26'($urandom())};
  endfunction

  // ---------------- driver / scoreboard ----------------
  // Called just after a rising edge; samples at the falling edge, returns just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (out_valid && !out_ready && exp_q.size() > 0)
      check_eq("hold", 64'(get_out()), 64'(exp_q[0]));
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check_eq("spurious_out", 64'(1), 64'(0));
      else check_eq("out", 64'(get_out()), 64'(exp_q.pop_front()));
    end
    in_fired = in_valid && in_ready;
    if (in_fired && !flush) exp_q.push_back(model(in_instr));
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] ins);
    in_instr = ins;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles && (exp_q.size() > 0 || out_valid); i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    int n0;
    int exp_acc;
    logic [31:0] words [6];

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready_low", 64'(in_ready), 64'(0));
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    check_eq("rst_payload", 64'(get_out()), 64'(0));
    check_eq("rst_sticky", 64'(err_sticky), 64'(0));

    // Directed decode cases
    out_ready = 1'b1;
    send1(32'h04611000);
    check_eq("add_valid", 64'(out_valid), 64'(1));
    check_eq("add_cmd", 64'(exe_cmd), 64'(0));
    check_eq("add_wb", 64'(wb_en), 64'(1));
    check_eq("add_dest", 64'(dest), 64'(3));
    check_eq("add_src1", 64'(src1), 64'(1));
    check_eq("add_src2", 64'(src2), 64'(2));
    step();

    send1({6'd32, 5'd4, 5'd2, 16'hFFF0});
    check_eq("addi_imm", 64'(imm_ext), 64'(32'hFFFFFFF0));
    check_eq("addi_is_imm", 64'(is_imm), 64'(1));
    step();
    send1({6'd11, 5'd7, 5'd6, 16'h2800});
    check_eq("sra_cmd", 64'(exe_cmd), 64'(4'b1001));
    step();
    send1({6'd10, 5'd7, 5'd6, 16'h2800});
    check_eq("sll_cmd", 64'(exe_cmd), 64'(4'b1011));
    step();
    send1({6'd37, 5'd1, 5'd2, 16'h0010});
    check_eq("st_mem_wr", 64'(mem_wr), 64'(1));
    check_eq("st_wb", 64'(wb_en), 64'(0));
    step();
    check_eq("directed_drained", 64'(exp_q.size()), 64'(0));

    // Back-to-back: 8 words, 8 outputs on consecutive cycles
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) check_eq("b2b_valid", 64'(out_valid), 64'(1));
      in_instr = rand_instr();
      in_valid = 1'b1;
      step();
      check_eq("b2b_accept", 64'(in_fired), 64'(1));
    end
    in_valid = 1'b0;
    check_eq("b2b_last_valid", 64'(out_valid), 64'(1));
    step();
    check_eq("b2b_count", 64'(n_out - n0), 64'(8));
    check_eq("b2b_empty", 64'(out_valid), 64'(0));

    // Stall for 5 cycles with input offered every cycle
    for (int i = 0; i < 6; i++) words[i] = rand_instr();
`ifdef ID_EXE_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif
    n0 = n_out;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_instr = words[idx];
      in_valid = 1'b1;
      step();
      if (in_fired) idx++;
    end
    check_eq("stall_accepted", 64'(idx), 64'(exp_acc));
    check_eq("stall_in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    drain(10);
    check_eq("stall_no_loss", 64'(n_out - n0), 64'(exp_acc));
    check_eq("stall_drained", 64'(exp_q.size()), 64'(0));

    // Flush with the output stalled and an illegal word offered
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_instr = rand_instr();
      in_valid = 1'b1;
      step();
    end
    check_eq("flush_pre_valid", 64'(out_valid), 64'(1));
    in_instr = {6'd63, 26'h0};
    flush = 1'b1;
    #1;
    check_eq("flush_in_ready", 64'(in_ready), 64'(1));
    step();
    check_eq("flush_consumed", 64'(in_fired), 64'(1));
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_out_valid", 64'(out_valid), 64'(0));
    check_eq("flush_sticky", 64'(err_sticky), 64'(0));
    step();
    check_eq("flush_no_skid", 64'(out_valid), 64'(0));

    // Illegal opcode, then legal words keep the sticky flag
    out_ready = 1'b1;
    send1({6'd63, 5'd9, 5'd8, 16'h1234});
    check_eq("ill_flag", 64'(illegal), 64'(1));
    check_eq("ill_cmd", 64'(exe_cmd), 64'(0));
    check_eq("ill_wb", 64'(wb_en), 64'(0));
    check_eq("ill_sticky", 64'(err_sticky), 64'(1));
    step();
    send1({6'd3, 5'd1, 5'd2, 16'h1800});
    check_eq("legal_after_ill", 64'(illegal), 64'(0));
    step();
    send1({6'd5, 5'd4, 5'd5, 16'h3000});
    step();
    check_eq("sticky_holds", 64'(err_sticky), 64'(1));

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send1(32'h04611000);
    in_instr = rand_instr();
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'(0));
    check_eq("arst_payload", 64'(get_out()), 64'(0));
    check_eq("arst_sticky", 64'(err_sticky), 64'(0));
    check_eq("arst_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("arst_release_ready", 64'(in_ready), 64'(1));
    check_eq("arst_release_valid", 64'(out_valid), 64'(0));

    // Random tail with random output back-pressure
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(1, 0));
      in_valid  = 1'($urandom_range(1, 0));
      in_instr  = rand_instr();
      step();
    end
    in_valid = 1'b0;
    drain(10);
    check_eq("final_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
